pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage boundary register with stall/bubble/flush
// handling, a multicycle temporary/step-count feedback path, and optional
// performance counters enabled by defining the macro PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        TMP_W       = 64,
    parameter int unsigned        CNT_W       = 2,
    parameter int unsigned        STALL_W     = 6,
    parameter int unsigned        STAGE       = 3,
    parameter logic [DATA_W-1:0]  NOP_PAYLOAD = '0,
    parameter int unsigned        PERF_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_payload,
    input  logic [TMP_W-1:0]   tmp_i,
    input  logic [CNT_W-1:0]   cnt_i,
    input  logic               perf_clr,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_payload,
    output logic [TMP_W-1:0]   tmp_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [PERF_W-1:0]  stall_cycles,
    output logic [PERF_W-1:0]  flush_count
);

    // This stage's own stall request and the downstream stage's request.
    logic s_bit;
    logic d_bit;
    assign s_bit = stall[STAGE];
    assign d_bit = stall[STAGE+1];

    // Only two bits of the stall vector matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall;

    // Stage register: reset, then flush, bubble, advance, hold in priority order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_payload <= NOP_PAYLOAD;
            tmp_o       <= '0;
            cnt_o       <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_payload <= NOP_PAYLOAD;
            tmp_o       <= '0;
            cnt_o       <= '0;
        end else if (s_bit && !d_bit) begin
            // Downstream keeps moving while we stall: insert a bubble.
            out_valid   <= 1'b0;
            out_payload <= NOP_PAYLOAD;
            tmp_o       <= tmp_i;
            cnt_o       <= cnt_i;
        end else if (!s_bit) begin
            // Payload captured even when invalid; downstream qualifies with out_valid.
            out_valid   <= in_valid;
            out_payload <= in_payload;
            tmp_o       <= '0;
            cnt_o       <= '0;
        end else begin
            // Both stalled: keep the instruction, keep feeding back multicycle state.
            tmp_o       <= tmp_i;
            cnt_o       <= cnt_i;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    // Saturating stall/flush event counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst || perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (s_bit && !flush && (stall_cnt != PERF_MAX)) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (flush && (flush_cnt != PERF_MAX)) begin
                flush_cnt <= flush_cnt + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt;
    assign flush_count  = flush_cnt;
`else
    // Counters compiled out: report zero and ignore the clear request.
    logic unused_perf;
    assign unused_perf  = perf_clr;
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
